// File: rtl/piso_arb_ctrl_if.sv
// Requester-side handshake and shift-register control bundle for piso_arb_ctrl.
// The arbiter uses the slave modport; the requester/stimulus side uses master.
interface piso_arb_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [1:0]       req_lsb;
    logic [1:0]       req_ready;
    logic             piso_load;
    logic             piso_lsb;
    logic [WIDTH-1:0] piso_data;
    logic             bit_valid;
    logic             gnt_id;
    logic             busy;
    logic             frame_done;

    modport master (
        output req_valid, req_data0, req_data1, req_lsb,
        input  req_ready, piso_load, piso_lsb, piso_data, bit_valid, gnt_id, busy, frame_done
    );

    modport slave (
        input  req_valid, req_data0, req_data1, req_lsb,
        output req_ready, piso_load, piso_lsb, piso_data, bit_valid, gnt_id, busy, frame_done
    );
endinterface

// File: rtl/piso_arb_ctrl.sv
// Two-requester round-robin arbiter that feeds one parallel-in/serial-out shift
// register, framing each word as LOAD, WIDTH shift cycles and an optional idle gap.
module piso_arb_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input logic            clk,
    input logic            resetn,
    piso_arb_ctrl_if.slave bus
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
    localparam logic [3:0]      LastGap = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

    state_e           state_q;
    logic [CntW-1:0]  bit_cnt_q;
    logic [3:0]       gap_cnt_q;
    logic             last_q;
    logic             piso_load_q;
    logic             piso_lsb_q;
    logic [WIDTH-1:0] piso_data_q;
    logic             bit_valid_q;
    logic             gnt_q;
    logic             frame_done_q;
    logic [1:0]       grant;

    // Ready is offered only in IDLE and never while reset is held.
    always_comb begin
        grant = 2'b00;
        if (state_q == StIdle && resetn) begin
            unique case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            last_q       <= 1'b1;
            piso_load_q  <= 1'b0;
            piso_lsb_q   <= 1'b0;
            piso_data_q  <= '0;
            bit_valid_q  <= 1'b0;
            gnt_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            piso_load_q  <= 1'b0;
            frame_done_q <= 1'b0;
            bit_valid_q  <= (state_q == StShift);
            unique case (state_q)
                StIdle: begin
                    if (|grant) begin
                        state_q     <= StLoad;
                        piso_load_q <= 1'b1;
                        gnt_q       <= grant[1];
                        last_q      <= grant[1];
                        piso_data_q <= grant[1] ? bus.req_data1 : bus.req_data0;
                        piso_lsb_q  <= grant[1] ? bus.req_lsb[1] : bus.req_lsb[0];
                        bit_cnt_q   <= '0;
                    end
                end
                StLoad: begin
                    state_q <= StShift;
                end
                StShift: begin
                    if (bit_cnt_q == LastBit) begin
                        frame_done_q <= 1'b1;
                        gap_cnt_q    <= '0;
                        state_q      <= (GAP_CYCLES == 0) ? StIdle : StGap;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CntW'(1);
                    end
                end
                StGap: begin
                    if (gap_cnt_q == LastGap) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready  = grant;
    assign bus.piso_load  = piso_load_q;
    assign bus.piso_lsb   = piso_lsb_q;
    assign bus.piso_data  = piso_data_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.gnt_id     = gnt_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Self-checking bench for piso_arb_ctrl: directed frame table, multi-cycle corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_piso_arb_ctrl;

    localparam int unsigned W = 8;
    localparam int unsigned G = 1;

    logic clk = 1'b0;
    logic resetn;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    piso_arb_ctrl_if #(.WIDTH(W)) bus ();
    piso_arb_ctrl_if #(.WIDTH(W)) bus0 ();

    piso_arb_ctrl #(.WIDTH(W), .GAP_CYCLES(G)) dut (.clk(clk), .resetn(resetn), .bus(bus));
    piso_arb_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));

    // Downstream shift register driven by the arbiter; serial output is registered.
    logic [W-1:0] sreg;
    logic         sout;
    always @(posedge clk) begin
        if (bus.piso_load) begin
            sreg <= bus.piso_data;
        end else begin
            sout <= bus.piso_lsb ? sreg[0] : sreg[W-1];
            sreg <= bus.piso_lsb ? (sreg >> 1) : (sreg << 1);
        end
    end

    typedef struct {
        logic [1:0]   valid;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [1:0]   lsb;
        logic [1:0]   exp_ready;
        logic [W-1:0] exp_stream;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, 32'(bus.req_ready), 32'd0);
        check({name, "_load"}, 32'(bus.piso_load), 32'd0);
        check({name, "_lsb"}, 32'(bus.piso_lsb), 32'd0);
        check({name, "_data"}, 32'(bus.piso_data), 32'd0);
        check({name, "_bitv"}, 32'(bus.bit_valid), 32'd0);
        check({name, "_gnt"}, 32'(bus.gnt_id), 32'd0);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_done"}, 32'(bus.frame_done), 32'd0);
    endtask

    // Holds reset two cycles with both requesters asserting, then releases at a negedge.
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        bus.req_valid = 2'b11;
        bus0.req_valid = 2'b00;
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        bus.req_valid = 2'b00;
        resetn = 1'b1;
    endtask

    task automatic run_frame(input string name, input logic [1:0] valid, input logic [W-1:0] d0,
                             input logic [W-1:0] d1, input logic [1:0] lsb,
                             input logic [1:0] exp_ready, input logic [W-1:0] exp_stream);
        logic         exp_id;
        logic [W-1:0] stream;
        int           nb;
        logic         done;
        exp_id = exp_ready[1];
        bus.req_valid = valid;
        bus.req_data0 = d0;
        bus.req_data1 = d1;
        bus.req_lsb   = lsb;
        #1;
        check({name, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        check({name, "_load"}, 32'(bus.piso_load), 32'd1);
        check({name, "_pdata"}, 32'(bus.piso_data), 32'(exp_id ? d1 : d0));
        check({name, "_plsb"}, 32'(bus.piso_lsb), 32'(lsb[exp_id]));
        check({name, "_gnt"}, 32'(bus.gnt_id), 32'(exp_id));
        stream = '0;
        nb     = 0;
        done   = 1'b0;
        for (int c = 0; c < 3 * W && !done; c++) begin
            @(negedge clk);
            #1;
            if (bus.bit_valid) begin
                stream = {stream[W-2:0], sout};
                nb++;
            end
            if (bus.frame_done) begin
                done = 1'b1;
                check({name, "_nbits"}, 32'(nb), 32'(W));
                check({name, "_done_bitv"}, 32'(bus.bit_valid), 32'd1);
            end
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        check({name, "_stream"}, 32'(stream), 32'(exp_stream));
        for (int c = 0; c < 40 && bus.busy; c++) @(negedge clk);
        check({name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{2'b01, 8'hA5, 8'h00, 2'b00, 2'b01, 8'hA5};
        tbl[1] = '{2'b11, 8'h33, 8'h01, 2'b10, 2'b10, 8'h80};
        tbl[2] = '{2'b11, 8'h0F, 8'h00, 2'b00, 2'b01, 8'h0F};
        tbl[3] = '{2'b01, 8'hC1, 8'h00, 2'b01, 2'b01, 8'h83};
        tbl[4] = '{2'b11, 8'h00, 8'hF0, 2'b00, 2'b10, 8'hF0};
        tbl[5] = '{2'b10, 8'hFF, 8'h96, 2'b10, 2'b10, 8'h69};

        resetn = 1'b0;
        bus.req_valid = 2'b00;  bus.req_data0 = '0;  bus.req_data1 = '0;  bus.req_lsb = 2'b00;
        bus0.req_valid = 2'b00; bus0.req_data0 = '0; bus0.req_data1 = '0; bus0.req_lsb = 2'b00;

        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].valid, tbl[i].d0, tbl[i].d1, tbl[i].lsb,
                      tbl[i].exp_ready, tbl[i].exp_stream);
        end

        // Both requesters held: first tie goes to 0, then strict alternation.
        begin
            int nacc = 0;
            int last_acc = 0;
            int pend_id = -1;
            do_reset();
            bus.req_valid = 2'b11; bus.req_data0 = 8'h0F; bus.req_data1 = 8'hF0; bus.req_lsb = 2'b00;
            for (int c = 0; c < 80 && nacc < 4; c++) begin
                #1;
                if (pend_id >= 0) begin
                    check("rr_gnt_id", 32'(bus.gnt_id), 32'(pend_id));
                    pend_id = -1;
                end
                if (bus.req_ready != 2'b00) begin
                    check("rr_grant", 32'(bus.req_ready), (nacc % 2 == 0) ? 32'd1 : 32'd2);
                    if (nacc > 0) check("rr_spacing", 32'(c - last_acc), 32'(W + 2 + G));
                    pend_id  = nacc % 2;
                    last_acc = c;
                    nacc++;
                end
                @(negedge clk);
            end
            check("rr_accepts", 32'(nacc), 32'd4);
            bus.req_valid = 2'b00;
        end

        // Reset on the 4th SHIFT cycle aborts the frame with no frame_done.
        do_reset();
        bus.req_valid = 2'b01; bus.req_data0 = 8'hA5; bus.req_lsb = 2'b00;
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (4) @(negedge clk);
        #1;
        check("mid_busy", 32'(bus.busy), 32'd1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check("mid_no_done", 32'(bus.frame_done), 32'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        run_frame("post_rst", 2'b10, 8'h00, 8'h5A, 2'b00, 2'b10, 8'h5A);

        // Zero-gap instance: back-to-back frames with a single IDLE cycle between them.
        begin
            int nacc = 0;
            int last_acc = 0;
            int idle_run = 0;
            do_reset();
            bus0.req_valid = 2'b10; bus0.req_data1 = 8'h3C; bus0.req_lsb = 2'b00;
            for (int c = 0; c < 80 && nacc < 4; c++) begin
                #1;
                if (!bus0.busy) idle_run++;
                if (bus0.req_ready != 2'b00) begin
                    check("gap0_ready", 32'(bus0.req_ready), 32'd2);
                    if (nacc > 0) begin
                        check("gap0_spacing", 32'(c - last_acc), 32'(W + 2));
                        check("gap0_idle", 32'(idle_run), 32'd1);
                    end
                    idle_run = 0;
                    last_acc = c;
                    nacc++;
                end
                @(negedge clk);
            end
            check("gap0_accepts", 32'(nacc), 32'd4);
            bus0.req_valid = 2'b00;
        end

        // Random traffic against a frame-level model: a frame occupies W+1+G busy cycles
        // after its accept, bits appear at ages 3..W+2 and frame_done at age W+2.
        begin
            int           rem = 0;
            int           age = 0;
            int           nb = 0;
            logic         last_m = 1'b1;
            logic         fid = 1'b0;
            logic [W-1:0] fdata = '0;
            logic         flsb = 1'b0;
            logic [W-1:0] stream = '0;
            logic [W-1:0] exp_s;
            logic [1:0]   v;
            logic [1:0]   l;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [1:0]   er;
            do_reset();
            for (int c = 0; c < 600; c++) begin
                v = 2'($urandom); l = 2'($urandom); a = W'($urandom); b = W'($urandom);
                bus.req_valid = v; bus.req_lsb = l; bus.req_data0 = a; bus.req_data1 = b;
                #1;
                er = 2'b00;
                if (rem == 0) begin
                    if (v == 2'b01) er = 2'b01;
                    else if (v == 2'b10) er = 2'b10;
                    else if (v == 2'b11) er = last_m ? 2'b01 : 2'b10;
                end
                check("rnd_ready", 32'(bus.req_ready), 32'(er));
                check("rnd_busy", 32'(bus.busy), 32'(rem != 0));
                check("rnd_load", 32'(bus.piso_load), 32'(age == 1));
                check("rnd_bitv", 32'(bus.bit_valid), 32'(age >= 3 && age <= int'(W) + 2));
                check("rnd_done", 32'(bus.frame_done), 32'(age == int'(W) + 2));
                if (age >= 1 && age <= int'(W) + 1) begin
                    check("rnd_gnt", 32'(bus.gnt_id), 32'(fid));
                    check("rnd_pdata", 32'(bus.piso_data), 32'(fdata));
                    check("rnd_plsb", 32'(bus.piso_lsb), 32'(flsb));
                end
                if (bus.bit_valid) begin
                    stream = {stream[W-2:0], sout};
                    nb++;
                end
                if (age == int'(W) + 2) begin
                    for (int k = 0; k < int'(W); k++)
                        exp_s[W-1-k] = flsb ? fdata[k] : fdata[W-1-k];
                    check("rnd_nbits", 32'(nb), 32'(W));
                    check("rnd_stream", 32'(stream), 32'(exp_s));
                end
                if (er != 2'b00) begin
                    fid    = er[1];
                    fdata  = fid ? b : a;
                    flsb   = l[fid];
                    last_m = fid;
                    rem    = W + 1 + G;
                    age    = 1;
                    nb     = 0;
                    stream = '0;
                end else begin
                    if (rem > 0) rem--;
                    if (age > 0) age++;
                end
                @(negedge clk);
            end
            bus.req_valid = 2'b00;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/piso_arb_ctrl.md
PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, shall set the serialised word width in bits.
REQ-002 Parameter GAP_CYCLES, default 1, range 0..15, shall set the idle cycles inserted after each frame.
REQ-003 clk  input  1  shall be the single clock; all state updates on posedge clk.
REQ-004 resetn  input  1  shall be the reset, asynchronous and active-low.
REQ-005 req_valid  input  2  shall carry the per-requester word-available flag (bit i = requester i).
REQ-006 req_data0, req_data1  input  WIDTH each  shall carry the per-requester word.
REQ-007 req_lsb  input  2  shall carry the per-requester bit order (1 = LSB first, 0 = MSB first).
REQ-008 req_ready  output  2  shall be the per-requester accept strobe.
REQ-009 piso_load  output  1  shall drive the shift-register load control.
REQ-010 piso_lsb  output  1  shall drive the shift-register bit-order select.
REQ-011 piso_data  output  WIDTH  shall drive the shift-register parallel input.
REQ-012 bit_valid  output  1  shall qualify the serial output of the shift register.
REQ-013 gnt_id  output  1  shall identify the requester that owns the current frame.
REQ-014 busy  output  1  shall be high whenever state is not IDLE.
REQ-015 frame_done  output  1  shall be a one-cycle pulse at frame end.

Function
REQ-016 The FSM shall have exactly four states: IDLE, LOAD, SHIFT and GAP.
REQ-017 In IDLE, req_ready shall be combinational: at most one bit high, only for a requester whose req_valid is high.
REQ-018 A transfer shall be accepted on the posedge where req_valid[i] and req_ready[i] are both 1; the selected data and lsb shall be captured, gnt_id shall be set to i, and the FSM shall go to LOAD.
REQ-019 Arbitration shall be round-robin: with both requesters valid, grant shall go to the requester not granted last; after reset, requester 0 shall win the first tie.
REQ-020 With only one requester valid, that requester shall be granted regardless of round-robin history.
REQ-021 In LOAD, piso_load shall be 1 for exactly one cycle, piso_data shall equal the captured word, and the next state shall be SHIFT.
REQ-022 SHIFT shall last exactly WIDTH cycles with piso_load = 0, counted by a bit counter 0..WIDTH-1.
REQ-023 piso_data, piso_lsb and gnt_id shall be held stable from LOAD through the final SHIFT cycle.
REQ-024 bit_valid shall be a registered copy of (state == SHIFT): high for exactly WIDTH consecutive cycles, starting one cycle after the first SHIFT cycle, aligned with the shift register's registered serial output.
REQ-025 frame_done shall pulse high in the cycle after the last SHIFT cycle, coincident with the final bit_valid cycle.
REQ-026 After SHIFT, the FSM shall enter GAP for GAP_CYCLES cycles, or go directly to IDLE when GAP_CYCLES = 0.
REQ-027 req_ready shall be 0 in LOAD, SHIFT and GAP; a req_valid that drops before acceptance shall be ignored without error.
REQ-028 The minimum frame period (accept to accept) shall be WIDTH + 2 + GAP_CYCLES cycles.
REQ-029 The bit counter shall not wrap inside a frame; it shall clear on entry to LOAD.

Reset
REQ-030 While resetn = 0: state = IDLE, req_ready = 0, piso_load = 0, piso_lsb = 0, piso_data = 0, bit_valid = 0, gnt_id = 0, busy = 0, frame_done = 0, counters = 0, and round-robin pointer = last-granted requester 1.
REQ-031 Reset asserted mid-frame shall abort the frame immediately; no frame_done shall be generated for it.
REQ-032 After reset release, the first accept shall occur no earlier than the first posedge with resetn = 1.

Verification
REQ-033 req_valid = 01, req_data0 = 8'hA5, req_lsb = 0 -> req_ready = 01 for one cycle; piso_load high one cycle with piso_data = A5; bit_valid high 8 cycles; serial stream 1,0,1,0,0,1,0,1; frame_done on the 8th valid bit.
REQ-034 req_valid = 11 continuously after reset, data0 = 8'h0F, data1 = 8'hF0 -> grants alternate 0,1,0,1; gnt_id follows; accept spacing = 11 cycles (GAP_CYCLES = 1).
REQ-035 req_lsb = 1, data = 8'h01 -> first valid serial bit = 1, remaining seven bits = 0.
REQ-036 resetn pulled low on the 4th SHIFT cycle -> all outputs go to reset values asynchronously; no frame_done; a new request after release gets a full 8-bit frame.
REQ-037 GAP_CYCLES = 0 with req_valid = 10 held -> back-to-back frames 10 cycles apart; busy low for exactly one cycle (IDLE) between frames.
